// File: rtl/softmax_rmst_sched_pkg.sv
// softmax_rmst_sched_pkg: shared defaults, FSM state type and burst sizing for the read-master scheduler
package softmax_pkg;

    localparam int BEAT_BYTES_DEF = 16;
    localparam int MAX_BEATS_DEF  = 32;

    typedef enum logic [2:0] {IDLE, ARB, ISSUE, WAIT, NEXT} state_e;

    // Largest allowed burst first, then 16 and 8, otherwise whatever remains
    function automatic logic [63:0] burst_beats(input logic [63:0] rem, input logic [63:0] max_beats);
        return rem >= max_beats ? max_beats : rem >= 64'd16 ? 64'd16 : rem >= 64'd8 ? 64'd8 : rem;
    endfunction

endpackage

// File: rtl/softmax_rmst_sched_if.sv
// softmax_rmst_sched_if: requester handshake plus read-master control bundle
interface softmax_rmst_sched_if #(
    parameter int XAW  = 32,
    parameter int NREQ = 2
) ();
    localparam int IW = $clog2(NREQ);

    logic [NREQ-1:0]     req_valid;
    logic [NREQ-1:0]     req_ready;
    logic [NREQ*XAW-1:0] req_base;
    logic [NREQ*XAW-1:0] req_len;
    logic [NREQ-1:0]     req_done;
    logic [IW-1:0]       grant_id;
    logic                busy;
    logic                rmst_fixed_location;
    logic [XAW-1:0]      rmst_read_base;
    logic [XAW-1:0]      rmst_read_length;
    logic                rmst_go;
    logic                rmst_done;

    modport slave (
        input  req_valid, req_base, req_len, rmst_done,
        output req_ready, req_done, grant_id, busy,
               rmst_fixed_location, rmst_read_base, rmst_read_length, rmst_go
    );

    modport master (
        output req_valid, req_base, req_len, rmst_done,
        input  req_ready, req_done, grant_id, busy,
               rmst_fixed_location, rmst_read_base, rmst_read_length, rmst_go
    );

endinterface

// File: rtl/softmax_rmst_sched_rr_arbiter.sv
// rmst_rr_arbiter: picks one active context per burst; round-robin, or fixed priority when RMST_FIXED_PRIO_EN is defined
module rmst_rr_arbiter #(
    parameter int  NREQ = 2,
    localparam int IW   = $clog2(NREQ)
) (
    input  logic [NREQ-1:0] req_i,
    input  logic [IW-1:0]   last_i,
    output logic [NREQ-1:0] gnt_o,
    output logic [IW-1:0]   idx_o
);

    logic [IW-1:0] cand;

    // Scan candidates from lowest to highest rank so the best one is written last
    always_comb begin
        idx_o = '0;
        cand  = '0;
`ifdef RMST_FIXED_PRIO_EN
        for (int k = NREQ - 1; k >= 0; k--) begin
            cand = IW'(k);
            if (req_i[cand]) idx_o = cand;
        end
`else
        for (int k = NREQ; k >= 1; k--) begin
            cand = IW'((int'(last_i) + k) % NREQ);
            if (req_i[cand]) idx_o = cand;
        end
`endif
        gnt_o = |req_i ? NREQ'(1) << idx_o : '0;
    end

endmodule

// File: rtl/softmax_rmst_sched.sv
// softmax_rmst_sched: shares one read master between NREQ requesters, splitting transfers into bursts
// Build option: RMST_FIXED_PRIO_EN selects fixed priority (requester 0 first) in the arbiter.
module softmax_rmst_sched
    import softmax_pkg::*;
#(
    parameter int XAW        = 32,
    parameter int NREQ       = 2,
    parameter int BEAT_BYTES = BEAT_BYTES_DEF,
    parameter int MAX_BEATS  = MAX_BEATS_DEF
) (
    input logic                 clk,
    input logic                 rst,
    softmax_rmst_sched_if.slave bus
);

    localparam int IW = $clog2(NREQ);
    localparam int BS = $clog2(BEAT_BYTES);

    state_e          state_q, state_d;
    logic [XAW-1:0]  addr_q [NREQ];
    logic [XAW-1:0]  addr_d [NREQ];
    logic [XAW-1:0]  rem_q  [NREQ];
    logic [XAW-1:0]  rem_d  [NREQ];
    logic [NREQ-1:0] active_q, active_d, done_q, done_d, gnt_q, arb_gnt, accept;
    logic [IW-1:0]   grant_q, rr_q, arb_idx;
    logic [XAW-1:0]  base_q, len_q, beats_q, arb_beats, rem_left;
    logic            rmst_done_q;

    rmst_rr_arbiter #(.NREQ(NREQ)) u_arb (
        .req_i  (active_q),
        .last_i (rr_q),
        .gnt_o  (arb_gnt),
        .idx_o  (arb_idx)
    );

    // Burst size for the winning context and the remainder left after the current burst
    always_comb begin
        arb_beats = XAW'(burst_beats(64'(rem_q[arb_idx]), 64'(MAX_BEATS)));
        rem_left  = rem_q[grant_q] >= beats_q ? rem_q[grant_q] - beats_q : '0;
    end

    // Context updates: acceptance runs independently of the FSM, NEXT advances the granted context
    always_comb begin
        accept   = bus.req_valid & ~active_q;
        active_d = active_q;
        done_d   = '0;
        addr_d   = addr_q;
        rem_d    = rem_q;
        for (int i = 0; i < NREQ; i++) begin
            if (accept[i]) begin
                addr_d[i]   = bus.req_base[i*XAW +: XAW];
                rem_d[i]    = (bus.req_len[i*XAW +: XAW] >> BS)
                            + XAW'(|(bus.req_len[i*XAW +: XAW] & XAW'(BEAT_BYTES - 1)));
                active_d[i] = |bus.req_len[i*XAW +: XAW];
                done_d[i]   = ~|bus.req_len[i*XAW +: XAW];
            end
        end
        if (state_q == NEXT) begin
            addr_d[grant_q] = addr_q[grant_q] + len_q;
            rem_d[grant_q]  = rem_left;
            if (rem_left == '0) begin
                active_d = active_d & ~gnt_q;
                done_d   = done_d | gnt_q;
            end
        end
    end

    // Context storage, completion pulses and rmst_done history for edge detection
    always_ff @(posedge clk) begin
        if (!rst) begin
            addr_q      <= '{default: '0};
            rem_q       <= '{default: '0};
            active_q    <= '0;
            done_q      <= '0;
            rmst_done_q <= 1'b0;
        end else begin
            addr_q      <= addr_d;
            rem_q       <= rem_d;
            active_q    <= active_d;
            done_q      <= done_d;
            rmst_done_q <= bus.rmst_done;
        end
    end

    // FSM state register
    always_ff @(posedge clk) begin
        if (!rst) state_q <= IDLE;
        else      state_q <= state_d;
    end

    // FSM next state; a done level already high on entering WAIT is not an edge
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    state_d = |active_q ? ARB : IDLE;
            ARB:     state_d = ISSUE;
            ISSUE:   state_d = WAIT;
            WAIT:    state_d = (bus.rmst_done & ~rmst_done_q) ? NEXT : WAIT;
            NEXT:    state_d = |active_d ? ARB : IDLE;
            default: state_d = IDLE;
        endcase
    end

    // Latch the winner and its burst in ARB; these hold until the next ARB
    always_ff @(posedge clk) begin
        if (!rst) begin
            grant_q <= '0;
            rr_q    <= IW'(NREQ - 1);
            gnt_q   <= '0;
            base_q  <= '0;
            len_q   <= '0;
            beats_q <= '0;
        end else if (state_q == ARB) begin
            grant_q <= arb_idx;
            rr_q    <= arb_idx;
            gnt_q   <= arb_gnt;
            base_q  <= addr_q[arb_idx];
            beats_q <= arb_beats;
            len_q   <= arb_beats << BS;
        end
    end

    // FSM and context outputs
    always_comb begin
        bus.req_ready           = ~active_q;
        bus.req_done            = done_q;
        bus.grant_id            = grant_q;
        bus.busy                = (state_q != IDLE) | (|active_q);
        bus.rmst_fixed_location = 1'b0;
        bus.rmst_read_base      = base_q;
        bus.rmst_read_length    = len_q;
        bus.rmst_go             = state_q == ISSUE;
    end

endmodule
